// File: rtl/pdcch_rx_packer_pkg.sv
// Shared types for the PDCCH receive-side byte packer: FSM states and the output word layout.
package pdcch_rx_packer_pkg;

    localparam int PDCCH_RX_OUT_WIDTH = 32;

    // RX_FLUSH is only reachable when the idle-input watchdog is compiled in.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_PACK  = 2'd1,
        RX_FLUSH = 2'd2
    } pdcch_rx_state_t;

    typedef struct packed {
        logic [PDCCH_RX_OUT_WIDTH-1:0]   data;
        logic [PDCCH_RX_OUT_WIDTH/8-1:0] keep;
        logic                            last;
    } pdcch_rx_word_t;

endpackage

// File: rtl/pdcch_rx_packer_if.sv
// Stream bundle around the packer: length stream and byte stream in, packed word stream out.
interface pdcch_rx_packer_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32,
    parameter int LEN_WIDTH = 16
);
    logic [LEN_WIDTH-1:0]   s_axis_len_data;
    logic                   s_axis_len_valid;
    logic                   s_axis_len_ready;
    logic [IN_WIDTH-1:0]    s_axis_data;
    logic                   s_axis_valid;
    logic                   s_axis_ready;
    logic [OUT_WIDTH-1:0]   m_axis_data;
    logic [OUT_WIDTH/8-1:0] m_axis_keep;
    logic                   m_axis_last;
    logic                   m_axis_valid;
    logic                   m_axis_ready;

    // Environment side: feeds lengths and bytes, sinks packed words.
    modport master (
        output s_axis_len_data, s_axis_len_valid,
        input  s_axis_len_ready,
        output s_axis_data, s_axis_valid,
        input  s_axis_ready,
        input  m_axis_data, m_axis_keep, m_axis_last, m_axis_valid,
        output m_axis_ready
    );

    // Packer side.
    modport slave (
        input  s_axis_len_data, s_axis_len_valid,
        output s_axis_len_ready,
        input  s_axis_data, s_axis_valid,
        output s_axis_ready,
        output m_axis_data, m_axis_keep, m_axis_last, m_axis_valid,
        input  m_axis_ready
    );
endinterface

// File: rtl/pdcch_rx_packer.sv
// Packs pdcch_top output bytes little-endian into OUT_WIDTH-bit words with keep/last.
// Optional idle-input watchdog flush is enabled by defining PDCCH_RX_TIMEOUT_EN.
module pdcch_rx_packer
    import pdcch_rx_packer_pkg::*;
#(
    parameter int IN_WIDTH       = 8,
    parameter int OUT_WIDTH      = PDCCH_RX_OUT_WIDTH,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    pdcch_rx_packer_if.slave     bus,
    output logic [15:0]          frames_done,
    output logic                 timeout_flag
);

    localparam int BYTES_PER_WORD = OUT_WIDTH / 8;
    localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    generate
        if (IN_WIDTH != 8 || (OUT_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("pdcch_rx_packer: unsupported parameter set");
        end
    endgenerate

    pdcch_rx_state_t             state_q;
    logic [LEN_WIDTH-1:0]        remaining_q;
    logic [IDX_W-1:0]            idx_q;
    logic [OUT_WIDTH-1:0]        acc_q;
    logic [OUT_WIDTH-1:0]        out_data_q;
    logic [BYTES_PER_WORD-1:0]   out_keep_q;
    logic                        out_last_q;
    logic                        out_valid_q;
    logic [15:0]                 frames_q;

    logic                        out_free;
    logic                        byte_hs;
    logic                        xfer_last;
    logic                        word_done;
    logic [OUT_WIDTH-1:0]        merged_d;
    logic [OUT_WIDTH-1:0]        word_d;
    logic [BYTES_PER_WORD-1:0]   keep_d;

    assign out_free             = !out_valid_q || bus.m_axis_ready;
    assign bus.s_axis_ready     = (state_q == RX_PACK) && out_free;
    assign bus.s_axis_len_ready = (state_q == RX_IDLE);
    assign byte_hs              = bus.s_axis_valid && bus.s_axis_ready;
    assign xfer_last            = (remaining_q == LEN_ONE);
    assign word_done            = (idx_q == LAST_IDX) || xfer_last;

    always_comb begin
        merged_d = acc_q;
        merged_d[{idx_q, 3'b000} +: 8] = bus.s_axis_data;
    end

    // Lanes above the current byte index are forced to zero in the emitted word.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign keep_d[gi]          = (idx_q >= IDX_W'(gi));
            assign word_d[8*gi +: 8]   = keep_d[gi] ? merged_d[8*gi +: 8] : 8'h00;
        end
    endgenerate

`ifdef PDCCH_RX_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0]           wd_q;
    logic                      timeout_q;
    logic [BYTES_PER_WORD-1:0] flush_keep;

    // A flush keeps only the bytes already accumulated (idx of them).
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_flush_lane
            assign flush_keep[gi] = (idx_q > IDX_W'(gi));
        end
    endgenerate

    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            remaining_q <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frames_q    <= '0;
`ifdef PDCCH_RX_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            if (out_valid_q && bus.m_axis_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                RX_IDLE: begin
                    // A zero length is swallowed without starting a transfer.
                    if (bus.s_axis_len_valid && bus.s_axis_len_data != '0) begin
                        remaining_q <= bus.s_axis_len_data;
                        idx_q       <= '0;
                        acc_q       <= '0;
                        state_q     <= RX_PACK;
`ifdef PDCCH_RX_TIMEOUT_EN
                        wd_q        <= '0;
`endif
                    end
                end
                RX_PACK: begin
                    if (byte_hs) begin
                        remaining_q <= remaining_q - LEN_ONE;
`ifdef PDCCH_RX_TIMEOUT_EN
                        wd_q        <= '0;
`endif
                        if (word_done) begin
                            out_data_q  <= word_d;
                            out_keep_q  <= keep_d;
                            out_last_q  <= xfer_last;
                            out_valid_q <= 1'b1;
                            idx_q       <= '0;
                            acc_q       <= '0;
                            if (xfer_last) begin
                                state_q  <= RX_IDLE;
                                frames_q <= frames_q + 16'd1;
                            end
                        end else begin
                            acc_q <= merged_d;
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
`ifdef PDCCH_RX_TIMEOUT_EN
                    else if (wd_q == WD_LIMIT) begin
                        state_q <= RX_FLUSH;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`endif
                end
`ifdef PDCCH_RX_TIMEOUT_EN
                RX_FLUSH: begin
                    // Wait for the output register to drain before closing the transfer.
                    if (out_free) begin
                        out_data_q  <= acc_q;
                        out_keep_q  <= flush_keep;
                        out_last_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
                        acc_q       <= '0;
                        remaining_q <= '0;
                        timeout_q   <= 1'b1;
                        state_q     <= RX_IDLE;
                    end
                end
`endif
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign bus.m_axis_data  = out_data_q;
    assign bus.m_axis_keep  = out_keep_q;
    assign bus.m_axis_last  = out_last_q;
    assign bus.m_axis_valid = out_valid_q;
    assign frames_done      = frames_q;

endmodule

// File: tb/tb_pdcch_rx_packer.sv
// Directed table-driven bench for pdcch_rx_packer plus hand-written stall/reset/timeout sequences.
module tb_pdcch_rx_packer;
    import pdcch_rx_packer_pkg::*;

`ifdef PDCCH_RX_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] frames_done;
    logic        timeout_flag;

    pdcch_rx_packer_if #(.IN_WIDTH(8), .OUT_WIDTH(32), .LEN_WIDTH(16)) bus ();

    pdcch_rx_packer #(
        .IN_WIDTH(8), .OUT_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .frames_done(frames_done),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    pdcch_rx_word_t got_q[$];

    typedef struct {
        int                    len;
        logic [7:0]            base;
        int                    nwords;
        pdcch_rx_word_t [2:0]  exp;
    } vec_t;

    vec_t vecs[6];

    always @(negedge clk) begin
        if (bus.m_axis_valid && bus.m_axis_ready) begin
            got_q.push_back({bus.m_axis_data, bus.m_axis_keep, bus.m_axis_last});
            $display("word: data=0x%08h keep=0x%0h last=%0b frames_done=%0d",
                     bus.m_axis_data, bus.m_axis_keep, bus.m_axis_last, frames_done);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 40000 cycles");
        $fatal(1, "global timeout");
    end

    function automatic pdcch_rx_word_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        pdcch_rx_word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Length handshake, then nbytes bytes base, base+step, ...
    task automatic send(input int len, input int nbytes, input logic [7:0] base, input logic [7:0] step);
        int budget;
        bit ok;
        bus.s_axis_len_data  = 16'(len);
        bus.s_axis_len_valid = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            ok = bus.s_axis_len_ready;
            tick();
            budget++;
        end while (!ok && budget < 100);
        bus.s_axis_len_valid = 1'b0;
        chk("len_handshake", 64'(ok), 64'd1);
        for (int i = 0; i < nbytes; i++) begin
            bus.s_axis_data  = base + 8'(i) * step;
            bus.s_axis_valid = 1'b1;
            budget = 0;
            do begin
                @(negedge clk);
                ok = bus.s_axis_ready;
                tick();
                budget++;
            end while (!ok && budget < 200);
            chk($sformatf("byte_handshake_%0d", i), 64'(ok), 64'd1);
        end
        bus.s_axis_valid = 1'b0;
    endtask

    task automatic wait_words(input string name, input int n);
        int b = 0;
        while (got_q.size() < n && b < 100) begin
            @(negedge clk);
            b++;
        end
        repeat (3) tick();
        chk(name, 64'(got_q.size()), 64'(n));
    endtask

    initial begin
        vecs[0].len = 8;  vecs[0].base = 8'h01; vecs[0].nwords = 2;
        vecs[0].exp[0] = mk(32'h04030201, 4'hF, 1'b0);
        vecs[0].exp[1] = mk(32'h08070605, 4'hF, 1'b1);
        vecs[0].exp[2] = '0;
        vecs[1].len = 5;  vecs[1].base = 8'hA0; vecs[1].nwords = 2;
        vecs[1].exp[0] = mk(32'hA3A2A1A0, 4'hF, 1'b0);
        vecs[1].exp[1] = mk(32'h000000A4, 4'h1, 1'b1);
        vecs[1].exp[2] = '0;
        vecs[2].len = 1;  vecs[2].base = 8'h5A; vecs[2].nwords = 1;
        vecs[2].exp[0] = mk(32'h0000005A, 4'h1, 1'b1);
        vecs[2].exp[1] = '0;  vecs[2].exp[2] = '0;
        vecs[3].len = 6;  vecs[3].base = 8'h10; vecs[3].nwords = 2;
        vecs[3].exp[0] = mk(32'h13121110, 4'hF, 1'b0);
        vecs[3].exp[1] = mk(32'h00001514, 4'h3, 1'b1);
        vecs[3].exp[2] = '0;
        vecs[4].len = 3;  vecs[4].base = 8'hC0; vecs[4].nwords = 1;
        vecs[4].exp[0] = mk(32'h00C2C1C0, 4'h7, 1'b1);
        vecs[4].exp[1] = '0;  vecs[4].exp[2] = '0;
        vecs[5].len = 4;  vecs[5].base = 8'h30; vecs[5].nwords = 1;
        vecs[5].exp[0] = mk(32'h33323130, 4'hF, 1'b1);
        vecs[5].exp[1] = '0;  vecs[5].exp[2] = '0;

        reset                = 1'b1;
        bus.s_axis_len_data  = '0;
        bus.s_axis_len_valid = 1'b0;
        bus.s_axis_data      = '0;
        bus.s_axis_valid     = 1'b0;
        bus.m_axis_ready     = 1'b1;
        repeat (3) tick();
        chk("rst_m_valid", 64'(bus.m_axis_valid), 64'd0);
        chk("rst_m_data", 64'(bus.m_axis_data), 64'd0);
        chk("rst_m_keep", 64'(bus.m_axis_keep), 64'd0);
        chk("rst_m_last", 64'(bus.m_axis_last), 64'd0);
        chk("rst_frames", 64'(frames_done), 64'd0);
        chk("rst_timeout", 64'(timeout_flag), 64'd0);
        chk("rst_s_ready", 64'(bus.s_axis_ready), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_len_ready", 64'(bus.s_axis_len_ready), 64'd1);

        for (int v = 0; v < 6; v++) begin
            got_q.delete();
            send(vecs[v].len, vecs[v].len, vecs[v].base, 8'h01);
            wait_words($sformatf("v%0d_count", v), vecs[v].nwords);
            exp_frames++;
            for (int i = 0; i < vecs[v].nwords; i++)
                chk($sformatf("v%0d_word%0d", v, i), 64'(got_q[i]), 64'(vecs[v].exp[i]));
            chk($sformatf("v%0d_frames", v), 64'(frames_done), 64'(exp_frames));
        end

        // Zero length is a no-op, then a single-byte transfer.
        got_q.delete();
        send(0, 0, 8'h00, 8'h00);
        repeat (10) tick();
        chk("len0_no_words", 64'(got_q.size()), 64'd0);
        chk("len0_frames", 64'(frames_done), 64'(exp_frames));
        chk("len0_still_idle", 64'(bus.s_axis_len_ready), 64'd1);
        send(1, 1, 8'h5A, 8'h01);
        wait_words("len1_count", 1);
        exp_frames++;
        chk("len1_word", 64'(got_q[0]), 64'(mk(32'h0000005A, 4'h1, 1'b1)));
        chk("len1_frames", 64'(frames_done), 64'(exp_frames));

        // Downstream stall after the first word of a 12-byte transfer.
        got_q.delete();
        fork
            send(12, 12, 8'h40, 8'h01);
            begin
                int b = 0;
                while (got_q.size() < 1 && b < 100) begin
                    @(negedge clk);
                    b++;
                end
                @(posedge clk);
                #1;
                bus.m_axis_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (bus.m_axis_valid)
                        chk("stall_s_ready_low", 64'(bus.s_axis_ready), 64'd0);
                end
                chk("stall_word_held", 64'(bus.m_axis_valid), 64'd1);
                @(posedge clk);
                #1;
                bus.m_axis_ready = 1'b1;
            end
        join
        wait_words("stall_count", 3);
        exp_frames++;
        chk("stall_word0", 64'(got_q[0]), 64'(mk(32'h43424140, 4'hF, 1'b0)));
        chk("stall_word1", 64'(got_q[1]), 64'(mk(32'h47464544, 4'hF, 1'b0)));
        chk("stall_word2", 64'(got_q[2]), 64'(mk(32'h4B4A4948, 4'hF, 1'b1)));
        chk("stall_frames", 64'(frames_done), 64'(exp_frames));

        // Reset in the middle of a transfer discards the partial word.
        got_q.delete();
        send(8, 3, 8'h60, 8'h01);
        chk("midrst_no_words", 64'(got_q.size()), 64'd0);
        reset = 1'b1;
        tick();
        chk("midrst_m_valid", 64'(bus.m_axis_valid), 64'd0);
        chk("midrst_m_data", 64'(bus.m_axis_data), 64'd0);
        chk("midrst_m_keep", 64'(bus.m_axis_keep), 64'd0);
        chk("midrst_m_last", 64'(bus.m_axis_last), 64'd0);
        chk("midrst_frames", 64'(frames_done), 64'd0);
        chk("midrst_s_ready", 64'(bus.s_axis_ready), 64'd0);
        reset = 1'b0;
        exp_frames = 0;
        tick();
        send(4, 4, 8'h70, 8'h01);
        wait_words("postrst_count", 1);
        exp_frames++;
        chk("postrst_word", 64'(got_q[0]), 64'(mk(32'h73727170, 4'hF, 1'b1)));
        chk("postrst_frames", 64'(frames_done), 64'(exp_frames));

`ifdef PDCCH_RX_TIMEOUT_EN
        got_q.delete();
        chk("tmo_flag_before", 64'(timeout_flag), 64'd0);
        send(8, 3, 8'h11, 8'h11);
        begin
            int n = 0;
            while (got_q.size() < 1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("tmo_latency_in_range", 64'(n >= TMO && n <= TMO + 4), 64'd1);
        end
        repeat (3) tick();
        chk("tmo_count", 64'(got_q.size()), 64'd1);
        chk("tmo_word", 64'(got_q[0]), 64'(mk(32'h00332211, 4'h7, 1'b1)));
        chk("tmo_flag", 64'(timeout_flag), 64'd1);
        chk("tmo_frames", 64'(frames_done), 64'(exp_frames));
        got_q.delete();
        send(4, 4, 8'h80, 8'h01);
        wait_words("tmo_recover_count", 1);
        exp_frames++;
        chk("tmo_recover_word", 64'(got_q[0]), 64'(mk(32'h83828180, 4'hF, 1'b1)));
        chk("tmo_flag_sticky", 64'(timeout_flag), 64'd1);
        chk("tmo_recover_frames", 64'(frames_done), 64'(exp_frames));
`else
        chk("timeout_flag_tied_low", 64'(timeout_flag), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
